decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered RV32I integer decode stage with a valid/ready handshake on both sides. It sits between fetch and execute. It decodes the full load, store, OP-IMM and OP integer subsets and flags any other encoding as illegal. A 2-entry skid buffer keeps in_ready a pure register output, and a saturating counter records illegal instructions for debug.

Parameters:
DATA_WIDTH, 32, instruction and pc width
REG_ADDR_WIDTH, $clog2(DATA_WIDTH), register index width (5)
CNT_WIDTH, 16, illegal-instruction counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  drop all buffered and incoming instructions this cycle
in_valid  in  1  fetch beat valid
in_ready  out  1  stage can accept a beat (registered)
in_instr  in  DATA_WIDTH  raw instruction
in_pc  in  DATA_WIDTH  instruction address
out_valid  out  1  decoded beat valid
out_ready  in  1  execute accepts beat
out_pc  out  DATA_WIDTH  pc of decoded beat
out_alu_op  out  4  alu_op_t (isa_shared)
out_imm_op  out  3  imm_op_t (isa_shared)
out_mem_read  out  1  load
out_mem_write  out  1  store
out_mem_size  out  2  0=byte, 1=half, 2=word
out_mem_unsigned  out  1  lbu/lhu
out_reg_write  out  1  writes rd
out_rs1, out_rs2, out_rd  out  REG_ADDR_WIDTH each  register indices
out_illegal  out  1  unsupported encoding
illegal_count  out  CNT_WIDTH  saturating illegal counter

Behaviour:
- Reset (async): state EMPTY, out_valid=0, in_ready=1, illegal_count=0. All payload outputs are 0, with out_alu_op=ALU_NOP and out_imm_op=IMM_NOP.
- Accept on in_valid&&in_ready. Deliver on out_valid&&out_ready. Order is strictly FIFO.
- Decode is combinational on in_instr and registered on accept. Latency is 1 cycle from accept to out_valid when the stage is EMPTY.
- States: EMPTY (0 held), ONE (main reg), TWO (main+skid). in_ready=(state!=TWO), registered.
  - EMPTY: accept -> ONE.
  - ONE: accept and no deliver -> TWO (beat to skid). Deliver and no accept -> EMPTY. Both -> ONE (main reloads with new beat).
  - TWO: deliver -> ONE (skid moves to main). No accept is possible.
- Payload is held stable while out_valid&&!out_ready.
- flush has priority over everything: next state EMPTY, out_valid=0, in_ready=1. A beat presented in the flush cycle is dropped and not counted.
- Decode table:
  - LOAD 0000011: funct3 000/001/010/100/101 = lb/lh/lw/lbu/lhu. alu ADD, imm I, mem_read=1, rd/rs1 used, size and unsigned set from funct3.
  - STORE 0100011: funct3 000/001/010. alu ADD, imm S, mem_write=1, rs1/rs2 used, reg_write=0.
  - OP-IMM 0010011: addi/slti/sltiu/xori/ori/andi use imm I. slli/srli/srai use imm SHAMT. funct7 for shifts must be 0000000, or 0100000 for srai.
  - OP 0110011: funct7 0000000 gives all 8 ops. funct7 0100000 is legal only with funct3 000 (sub) and 101 (sra).
  - Anything else: out_illegal=1, all controls NOP/0, indices 0.
- Register indices not used by a format are driven to 0.
- reg_write is forced to 0 when rd==0.
- mem_read and mem_write are never both 1. The bench asserts this on every out_valid cycle.
- illegal_count increments on a delivered beat with out_illegal=1 and saturates at all-ones. Only reset clears it; flush does not.

Decomposition:
- isa_shared package:
  - alu_op_t: ALU_NOP, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - imm_op_t: IMM_NOP, IMM_I (replaces IMM_3120), IMM_S, IMM_SHAMT.
  - Opcode constants: OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP.
  - mem_size constants.
  - decoded_t packed struct.
- One sub-module, rv32i_decode_comb: purely combinational instr -> decoded_t. decode_stage wraps it with the skid buffer and the counter.

Test Plan:
- Reset, then one beat 0x00812283 (lw x5,8(x2)) with out_ready=1 -> next cycle out_valid=1, alu ADD, imm I, mem_read=1, size=2, rs1=2, rd=5, reg_write=1.
- 0x402081B3 (sub x3,x1,x2) then 0x0063A223 (sw x6,4(x7)) with out_ready=0 -> state TWO and in_ready=0 after the 2nd accept. Raise out_ready -> beats delivered in order, then in_ready=1. Second beat: mem_write=1, rs1=7, rs2=6, reg_write=0.
- 0xFFFFFFFF and 0x4000A033 (funct7 0100000, funct3 010) -> out_illegal=1, controls NOP, illegal_count increments by 1 per delivered beat. Preload the counter near all-ones -> it saturates.
- 0x00000013 (addi x0,x0,0) -> alu ADD, imm I, reg_write=0.
- State TWO, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed beats never appear, illegal_count unchanged.
- Assert rst asynchronously mid-stall in state TWO -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode types: ALU/immediate selectors, opcode constants and the
// decoded control word passed from decode to execute.
package isa_shared;

   localparam int REG_W = 5;

   typedef enum logic [3:0] {
      ALU_NOP  = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_SLL  = 4'd3,
      ALU_SLT  = 4'd4,
      ALU_SLTU = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_OR   = 4'd9,
      ALU_AND  = 4'd10
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_NOP   = 3'd0,
      IMM_I     = 3'd1,
      IMM_S     = 3'd2,
      IMM_SHAMT = 3'd3
   } imm_op_t;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [1:0] MEM_BYTE = 2'd0;
   localparam logic [1:0] MEM_HALF = 2'd1;
   localparam logic [1:0] MEM_WORD = 2'd2;

   typedef struct packed {
      alu_op_t          alu_op;
      imm_op_t          imm_op;
      logic             mem_read;
      logic             mem_write;
      logic [1:0]       mem_size;
      logic             mem_unsigned;
      logic             reg_write;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic             illegal;
   } decoded_t;

endpackage

// File: rtl/decode_stage_decode_comb.sv
// Purely combinational RV32I decoder for the load, store, OP-IMM and OP subsets;
// anything else comes out as an all-zero control word with illegal set.
module rv32i_decode_comb
   import isa_shared::*;
(
   input  logic [31:0] instr,
   output decoded_t    dec
);

   logic [6:0]       opcode;
   logic [2:0]       f3;
   logic [6:0]       f7;
   logic [REG_W-1:0] rs1, rs2, rd;
   logic             legal;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign f3     = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign f7     = instr[31:25];

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      dec   = '0;
      legal = 1'b0;
      case (opcode)
         OPC_LOAD: begin
            legal            = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            dec.alu_op       = ALU_ADD;
            dec.imm_op       = IMM_I;
            dec.mem_read     = 1'b1;
            dec.mem_size     = f3[1:0];
            dec.mem_unsigned = f3[2];
            dec.reg_write    = 1'b1;
            dec.rs1          = rs1;
            dec.rd           = rd;
         end
         OPC_STORE: begin
            legal         = !f3[2] && (f3[1:0] != 2'b11);
            dec.alu_op    = ALU_ADD;
            dec.imm_op    = IMM_S;
            dec.mem_write = 1'b1;
            dec.mem_size  = f3[1:0];
            dec.rs1       = rs1;
            dec.rs2       = rs2;
         end
         OPC_OPIMM: begin
            legal         = 1'b1;
            dec.imm_op    = IMM_I;
            dec.reg_write = 1'b1;
            dec.rs1       = rs1;
            dec.rd        = rd;
            case (f3)
               3'b000:  dec.alu_op = ALU_ADD;
               3'b010:  dec.alu_op = ALU_SLT;
               3'b011:  dec.alu_op = ALU_SLTU;
               3'b100:  dec.alu_op = ALU_XOR;
               3'b110:  dec.alu_op = ALU_OR;
               3'b111:  dec.alu_op = ALU_AND;
               3'b001: begin
                  dec.alu_op = ALU_SLL;
                  dec.imm_op = IMM_SHAMT;
                  legal      = (f7 == F7_BASE);
               end
               default: begin
                  dec.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  dec.imm_op = IMM_SHAMT;
                  legal      = (f7 == F7_BASE) || (f7 == F7_ALT);
               end
            endcase
         end
         OPC_OP: begin
            dec.reg_write = 1'b1;
            dec.rs1       = rs1;
            dec.rs2       = rs2;
            dec.rd        = rd;
            if (f7 == F7_BASE) begin
               legal = 1'b1;
               case (f3)
                  3'b000:  dec.alu_op = ALU_ADD;
                  3'b001:  dec.alu_op = ALU_SLL;
                  3'b010:  dec.alu_op = ALU_SLT;
                  3'b011:  dec.alu_op = ALU_SLTU;
                  3'b100:  dec.alu_op = ALU_XOR;
                  3'b101:  dec.alu_op = ALU_SRL;
                  3'b110:  dec.alu_op = ALU_OR;
                  default: dec.alu_op = ALU_AND;
               endcase
            end else if (f7 == F7_ALT) begin
               legal      = (f3 == 3'b000) || (f3 == 3'b101);
               dec.alu_op = (f3 == 3'b101) ? ALU_SRA : ALU_SUB;
            end
         end
         default: legal = 1'b0;
      endcase

      if (!legal) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
      // x0 is hardwired, so a write to it is suppressed here rather than in execute.
      if (dec.rd == '0) dec.reg_write = 1'b0;
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder in front of a 2-entry skid buffer so that
// in_ready is a flop, plus a saturating counter of delivered illegal beats.
module decode_stage
   import isa_shared::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = $clog2(DATA_WIDTH),
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_instr,
   input  logic [DATA_WIDTH-1:0]     in_pc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_pc,
   output logic [3:0]                out_alu_op,
   output logic [2:0]                out_imm_op,
   output logic                      out_mem_read,
   output logic                      out_mem_write,
   output logic [1:0]                out_mem_size,
   output logic                      out_mem_unsigned,
   output logic                      out_reg_write,
   output logic [REG_ADDR_WIDTH-1:0] out_rs1,
   output logic [REG_ADDR_WIDTH-1:0] out_rs2,
   output logic [REG_ADDR_WIDTH-1:0] out_rd,
   output logic                      out_illegal,
   output logic [CNT_WIDTH-1:0]      illegal_count
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      decoded_t              dec;
   } beat_t;

   state_t               state, state_next;
   beat_t                main_q, skid_q, in_beat;
   decoded_t             in_dec;
   logic                 out_valid_q, in_ready_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 accept, deliver;

   rv32i_decode_comb u_decode (
      .instr (in_instr[31:0]),
      .dec   (in_dec)
   );

   assign in_beat = '{pc: in_pc, dec: in_dec};
   assign accept  = in_valid && in_ready_q;
   assign deliver = out_valid_q && out_ready;

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY:   if (accept) state_next = ONE;
            ONE: begin
               if (accept && !deliver)      state_next = TWO;
               else if (deliver && !accept) state_next = EMPTY;
            end
            TWO:     if (deliver) state_next = ONE;
            default: state_next = EMPTY;
         endcase
      end
   end

   // Handshake flags are registered from the next state so both stay pure flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the payload registers are reset too, so outputs read as a clean NOP word.
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         main_q      <= '0;
         skid_q      <= '0;
         cnt_q       <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         state       <= state_next;
         out_valid_q <= (state_next != EMPTY);
         in_ready_q  <= (state_next != TWO);
         if (!flush) begin
            if (accept && (state == EMPTY || deliver)) main_q <= in_beat;
            else if (state == TWO && deliver)           main_q <= skid_q;
            if (accept && state == ONE && !deliver)     skid_q <= in_beat;
            if (deliver && main_q.dec.illegal && (cnt_q != '1))
               cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign in_ready         = in_ready_q;
   assign out_valid        = out_valid_q;
   assign out_pc           = main_q.pc;
   assign out_alu_op       = main_q.dec.alu_op;
   assign out_imm_op       = main_q.dec.imm_op;
   assign out_mem_read     = main_q.dec.mem_read;
   assign out_mem_write    = main_q.dec.mem_write;
   assign out_mem_size     = main_q.dec.mem_size;
   assign out_mem_unsigned = main_q.dec.mem_unsigned;
   assign out_reg_write    = main_q.dec.reg_write;
   assign out_rs1          = main_q.dec.rs1;
   assign out_rs2          = main_q.dec.rs2;
   assign out_rd           = main_q.dec.rd;
   assign out_illegal      = main_q.dec.illegal;
   assign illegal_count    = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push hand-decoded
// expectations; a negedge monitor pops and compares on every delivered beat.
module tb_decode_stage;
   import isa_shared::*;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic          in_ready, out_valid;
   logic [31:0]   in_instr, in_pc, out_pc;
   logic [3:0]    out_alu_op;
   logic [2:0]    out_imm_op;
   logic          out_mem_read, out_mem_write, out_mem_unsigned, out_reg_write, out_illegal;
   logic [1:0]    out_mem_size;
   logic [4:0]    out_rs1, out_rs2, out_rd;
   logic [CW-1:0] illegal_count;

   decode_stage #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_alu_op(out_alu_op), .out_imm_op(out_imm_op),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_mem_size(out_mem_size), .out_mem_unsigned(out_mem_unsigned),
      .out_reg_write(out_reg_write), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_illegal(out_illegal), .illegal_count(illegal_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  alu;
      logic [2:0]  imm;
      logic        mr, mw;
      logic [1:0]  size;
      logic        uns, rw;
      logic [4:0]  rs1, rs2, rd;
      logic        ill;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] pc, input alu_op_t a, input imm_op_t i,
                               input logic mr, input logic mw, input logic [1:0] size,
                               input logic uns, input logic rw,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd);
      return '{pc: pc, alu: a, imm: i, mr: mr, mw: mw, size: size, uns: uns, rw: rw,
               rs1: rs1, rs2: rs2, rd: rd, ill: 1'b0};
   endfunction

   function automatic exp_t mk_ill(input logic [31:0] pc);
      exp_t e = '0;
      e.pc  = pc;
      e.ill = 1'b1;
      return e;
   endfunction

   function automatic exp_t act_beat();
      return '{pc: out_pc, alu: out_alu_op, imm: out_imm_op, mr: out_mem_read,
               mw: out_mem_write, size: out_mem_size, uns: out_mem_unsigned,
               rw: out_reg_write, rs1: out_rs1, rs2: out_rs2, rd: out_rd, ill: out_illegal};
   endfunction

   // Monitor: inputs only change at posedge+1, so the negedge sees the handshake
   // exactly as the next rising edge will.
   exp_t prev_beat;
   logic prev_stall = 1'b0;
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         check("mem_rw_exclusive", {63'd0, out_mem_read & out_mem_write}, 64'd0);
         if (prev_stall) check("stall_stable", {3'd0, act_beat()}, {3'd0, prev_beat});
         if (out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got pc %0h expected no beat", out_pc);
            end else begin
               check("beat", {3'd0, act_beat()}, {3'd0, sb_q.pop_front()});
            end
         end
      end
      prev_stall = !rst && out_valid && !out_ready;
      prev_beat  = act_beat();
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e,
                       input bit track);
      int budget = 50;
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      if (track) sb_q.push_back(e);
      @(negedge clk);
      while (!in_ready && budget > 0) begin
         budget--;
         @(negedge clk);
      end
      if (budget == 0) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready %0b expected 1 for pc %0h", in_ready, pc);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_count", {60'd0, illegal_count}, 64'd0);
      check("rst_payload", {3'd0, act_beat()}, 64'd0);
      cycles(2);
      rst = 1'b0;
      cycles(1);

      // Single load, latency one cycle from accept.
      out_ready = 1'b1;
      send(32'h00812283, 32'h100, mk(32'h100, ALU_ADD, IMM_I, 1, 0, MEM_WORD, 0, 1, 5'd2, 5'd0, 5'd5), 1);
      check("lw_latency", {63'd0, out_valid}, 64'd1);
      cycles(2);

      // Back-pressure fills main and skid; in_ready drops.
      out_ready = 1'b0;
      send(32'h402081B3, 32'h104, mk(32'h104, ALU_SUB, IMM_NOP, 0, 0, 2'd0, 0, 1, 5'd1, 5'd2, 5'd3), 1);
      send(32'h0063A223, 32'h108, mk(32'h108, ALU_ADD, IMM_S, 0, 1, MEM_WORD, 0, 0, 5'd7, 5'd6, 5'd0), 1);
      check("two_in_ready", {63'd0, in_ready}, 64'd0);
      cycles(3);
      check("two_hold_ready", {63'd0, in_ready}, 64'd0);
      check("two_hold_valid", {63'd0, out_valid}, 64'd1);
      out_ready = 1'b1;
      cycles(3);
      check("drain_in_ready", {63'd0, in_ready}, 64'd1);
      check("drain_out_valid", {63'd0, out_valid}, 64'd0);

      // Illegal encodings.
      send(32'hFFFFFFFF, 32'h10C, mk_ill(32'h10C), 1);
      send(32'h4000A033, 32'h110, mk_ill(32'h110), 1);
      send(32'h02009093, 32'h114, mk_ill(32'h114), 1);
      cycles(2);
      check("ill_count_3", {60'd0, illegal_count}, 64'd3);

      // Legal OP-IMM and unsigned load.
      send(32'h00000013, 32'h118, mk(32'h118, ALU_ADD, IMM_I, 0, 0, 2'd0, 0, 0, 5'd0, 5'd0, 5'd0), 1);
      send(32'h0040C183, 32'h11C, mk(32'h11C, ALU_ADD, IMM_I, 1, 0, MEM_BYTE, 1, 1, 5'd1, 5'd0, 5'd3), 1);
      send(32'h4032D213, 32'h120, mk(32'h120, ALU_SRA, IMM_SHAMT, 0, 0, 2'd0, 0, 1, 5'd5, 5'd0, 5'd4), 1);
      cycles(2);
      check("legal_count_same", {60'd0, illegal_count}, 64'd3);

      // Flush from TWO with a beat presented: nothing comes out, counter unchanged.
      out_ready = 1'b0;
      send(32'hFFFFFFFF, 32'h200, mk_ill(32'h200), 0);
      send(32'h4000A033, 32'h204, mk_ill(32'h204), 0);
      in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h208; flush = 1'b1;
      cycles(1);
      flush = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", {63'd0, out_valid}, 64'd0);
      check("flush_in_ready", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      cycles(3);
      check("flush_stays_empty", {63'd0, out_valid}, 64'd0);
      check("flush_count", {60'd0, illegal_count}, 64'd3);

      // Saturation of the 4-bit counter.
      for (int i = 0; i < 12; i++) send(32'hFFFFFFFF, 32'h300 + 32'(4 * i), mk_ill(32'h300 + 32'(4 * i)), 1);
      cycles(2);
      check("count_full", {60'd0, illegal_count}, 64'd15);
      for (int i = 0; i < 2; i++) send(32'h4000A033, 32'h400 + 32'(4 * i), mk_ill(32'h400 + 32'(4 * i)), 1);
      cycles(2);
      check("count_saturated", {60'd0, illegal_count}, 64'd15);

      // Asynchronous reset mid-stall in TWO.
      out_ready = 1'b0;
      send(32'h00812283, 32'h500, '0, 0);
      send(32'h0063A223, 32'h504, '0, 0);
      check("pre_rst_two", {63'd0, in_ready}, 64'd0);
      #2;
      rst = 1'b1;
      #1;
      check("async_out_valid", {63'd0, out_valid}, 64'd0);
      check("async_in_ready", {63'd0, in_ready}, 64'd1);
      check("async_count", {60'd0, illegal_count}, 64'd0);
      cycles(2);
      rst = 1'b0;
      cycles(1);
      check("post_rst_empty", {63'd0, out_valid}, 64'd0);

      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
